// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline-register definitions: skid-stage states and occupancy encodings.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  function automatic logic [1:0] state_occ(input skid_state_e s);
    case (s)
      ST_ONE:  return OCC_ONE;
      ST_TWO:  return OCC_TWO;
      default: return OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter; sticks at all-ones once reached.
module sat_counter #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  output logic [CNTW-1:0] cnt
);

  logic [CNTW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register with flush, freeze and bubble accounting.
// in_ready depends only on local state, so out_ready never reaches it combinationally.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int DW   = 64,
  parameter int CW   = 8,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            freeze,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CW-1:0]   in_ctrl,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   out_ctrl,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      occupancy,
  output logic [CNTW-1:0] bubble_cnt
);

  skid_state_e   state_q, state_d;
  logic [CW-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DW-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic          rdy_en_q, rdy_en_d;
  logic          push, pop, bubble_inc;

  // rdy_en_q keeps in_ready low from reset release until the first unfrozen edge
  assign in_ready   = rdy_en_q & (state_q != ST_TWO) & ~freeze;
  assign out_valid  = (state_q != ST_EMPTY) & ~freeze;
  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign out_ctrl   = out_valid ? main_ctrl_q : '0;
  assign out_data   = main_data_q;
  assign occupancy  = state_occ(state_q);
  assign bubble_inc = ~freeze & ~flush & out_ready & (state_q == ST_EMPTY);

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    rdy_en_d    = rdy_en_q | ~freeze;
    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      // freeze forces push and pop low, so every branch below holds under freeze
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d     = ST_ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (push) begin
            state_d     = ST_TWO;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (pop) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d     = ST_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      rdy_en_q    <= rdy_en_d;
    end
  end

  sat_counter #(.CNTW(CNTW)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (bubble_inc),
    .cnt (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: accepted entries queue up, a negedge monitor checks deliveries.
module tb_pipe_skid_reg;
  localparam int DW = 16, CW = 8, CNTW = 4;

  logic            clk = 1'b0;
  logic            rst, flush, freeze, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0]   in_ctrl, out_ctrl;
  logic [DW-1:0]   in_data, out_data;
  logic [1:0]      occupancy;
  logic [CNTW-1:0] bubble_cnt;

  int checks = 0, failures = 0, cyc = 0;
  logic [CW+DW-1:0] exp_q[$];
  logic [DW-1:0]    got_q[$];
  int               got_cyc[$];

  pipe_skid_reg #(.DW(DW), .CW(CW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops before pushes so a same-cycle accept never overtakes the head
  always @(negedge clk) begin
    logic [CW+DW-1:0] e;
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected actual=%0h required=none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e[DW-1:0] || out_ctrl !== e[CW+DW-1:DW]) begin
            failures++;
            $display("FAIL sb_entry actual=%0h/%0h required=%0h/%0h",
                     out_ctrl, out_data, e[CW+DW-1:DW], e[DW-1:0]);
          end
        end
        got_q.push_back(out_data);
        got_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; freeze = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    repeat (3) tick();
    check("rst_occ", occupancy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_data", out_data, 0);
    check("rst_bubble", bubble_cnt, 0);

    // bubble counting with saturation at 15
    tick();
    rst = 1'b0; out_ready = 1'b1;
    check("rdy_before_edge", in_ready, 0);
    repeat (20) tick();
    check("bubble_sat", bubble_cnt, 15);
    check("rdy_after_edge", in_ready, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    check("bubble_flush_keep", bubble_cnt, 15);
    #2 rst = 1'b1;
    #1 check("bubble_rst_clear", bubble_cnt, 0);
    tick();
    rst = 1'b0;
    check("rdy_low_after_rst", in_ready, 0);
    tick();
    check("rdy_high_after_rst", in_ready, 1);

    // streaming 1..8
    got_q.delete(); got_cyc.delete();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = DW'(i); in_ctrl = CW'(8'h10 + i);
      tick();
      check("stream_occ", occupancy, 1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain_occ", occupancy, 0);
    check("stream_drain_valid", out_valid, 0);
    out_ready = 1'b0;
    tick();
    check("stream_bubble", bubble_cnt, 1);
    check("stream_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      check("stream_data", got_q[i], i + 1);
      if (i > 0) check("stream_gap", got_cyc[i] - got_cyc[i-1], 1);
    end

    // backpressure A,B,C
    got_q.delete();
    in_valid = 1'b1; in_data = 16'h000A; in_ctrl = 8'hA1;
    tick();
    in_data = 16'h000B; in_ctrl = 8'hB2;
    tick();
    in_data = 16'h000C; in_ctrl = 8'hC3;
    tick();
    check("bp_occ", occupancy, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_head_ctrl", out_ctrl, 8'hA1);
    tick();
    check("bp_occ_hold", occupancy, 2);
    out_ready = 1'b1;
    tick();
    check("bp_pop1_occ", occupancy, 1);
    check("bp_pop1_ctrl", out_ctrl, 8'hB2);
    tick();
    check("bp_pop2_ctrl", out_ctrl, 8'hC3);
    in_valid = 1'b0;
    tick();
    check("bp_drain_occ", occupancy, 0);
    out_ready = 1'b0;
    check("bp_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("bp_order0", got_q[0], 16'h000A);
      check("bp_order1", got_q[1], 16'h000B);
      check("bp_order2", got_q[2], 16'h000C);
    end

    // flush in TWO with push and pop requested
    got_q.delete();
    in_valid = 1'b1; in_data = 16'h000D; in_ctrl = 8'hD4;
    tick();
    in_data = 16'h000E; in_ctrl = 8'hE5;
    tick();
    check("fl_pre_occ", occupancy, 2);
    in_data = 16'h000F; in_ctrl = 8'hF6; out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("fl_occ", occupancy, 0);
    check("fl_out_valid", out_valid, 0);
    check("fl_out_ctrl", out_ctrl, 0);
    tick();
    check("fl_delivered", got_q.size(), 0);

    // freeze five cycles in ONE
    got_q.delete();
    in_valid = 1'b1; in_data = 16'h0007; in_ctrl = 8'h77;
    tick();
    check("fz_pre_occ", occupancy, 1);
    freeze = 1'b1; in_data = 16'h0008; in_ctrl = 8'h88; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fz_occ", occupancy, 1);
      check("fz_out_valid", out_valid, 0);
      check("fz_in_ready", in_ready, 0);
      check("fz_bubble", bubble_cnt, 1);
    end
    freeze = 1'b0;
    #1 check("fz_data_held", out_data, 16'h0007);
    check("fz_ctrl_held", out_ctrl, 8'h77);
    tick();
    check("fz_resume_ctrl", out_ctrl, 8'h88);
    in_valid = 1'b0;
    tick();
    check("fz_drain_occ", occupancy, 0);
    out_ready = 1'b0;
    check("fz_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("fz_order0", got_q[0], 16'h0007);
      check("fz_order1", got_q[1], 16'h0008);
    end
    check("fz_bubble_after", bubble_cnt, 1);

    // asynchronous reset between edges while in TWO
    got_q.delete();
    in_valid = 1'b1; in_data = 16'h0009; in_ctrl = 8'h99;
    tick();
    in_data = 16'h001A; in_ctrl = 8'hAA;
    tick();
    in_valid = 1'b0;
    check("ar_pre_occ", occupancy, 2);
    #2 rst = 1'b1;
    #1;
    check("ar_occ", occupancy, 0);
    check("ar_out_valid", out_valid, 0);
    check("ar_in_ready", in_ready, 0);
    check("ar_out_ctrl", out_ctrl, 0);
    check("ar_out_data", out_data, 0);
    check("ar_bubble", bubble_cnt, 0);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    check("ar_no_replay", got_q.size(), 0);
    check("ar_in_ready_back", in_ready, 1);
    in_valid = 1'b1; in_data = 16'h002B; in_ctrl = 8'hBB;
    tick();
    in_valid = 1'b0;
    tick();
    check("ar_post_count", got_q.size(), 1);
    if (got_q.size() == 1) check("ar_post_data", got_q[0], 16'h002B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DW, default 64, payload data width (operands, PC, immediates).
REQ-002 SHALL have parameter CW, default 8, control width (WB/MEM/branch/status enables, command); these bits are zeroed whenever the stage holds a bubble.
REQ-003 SHALL have parameter CNTW, default 16, bubble-counter width.
REQ-004 SHALL have port clk  in  1  clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush  in  1  synchronous kill of all held entries.
REQ-007 SHALL have port freeze  in  1  global hold (cache miss); no state changes while high.
REQ-008 SHALL have port in_valid  in  1  upstream entry present.
REQ-009 SHALL have port in_ready  out  1  stage can accept.
REQ-010 SHALL have port in_ctrl  in  CW  upstream control bits.
REQ-011 SHALL have port in_data  in  DW  upstream payload.
REQ-012 SHALL have port out_valid  out  1  entry presented downstream.
REQ-013 SHALL have port out_ready  in  1  downstream accepts.
REQ-014 SHALL have port out_ctrl  out  CW  control of presented entry.
REQ-015 SHALL have port out_data  out  DW  payload of presented entry.
REQ-016 SHALL have port occupancy  out  2  number of held entries, 0..2.
REQ-017 SHALL have port bubble_cnt  out  CNTW  saturating count of bubble cycles.

Function
REQ-018 SHALL hold two entries: main (drives outputs) and skid; states EMPTY, ONE, TWO.
REQ-019 SHALL define push = in_valid & in_ready, pop = out_valid & out_ready.
REQ-020 SHALL derive in_ready = (state != TWO) & ~freeze, with no combinational path from out_ready.
REQ-021 SHALL derive out_valid = (state != EMPTY) & ~freeze.
REQ-022 SHALL transition EMPTY->ONE on push (main <= in).
REQ-023 SHALL, in ONE: on push&pop stay ONE (main <= in); on push only go TWO (skid <= in); on pop only go EMPTY.
REQ-024 SHALL, in TWO: on pop go ONE (main <= skid); otherwise hold.
REQ-025 SHALL present an accepted entry on out_* the cycle after push: latency 1, throughput one per cycle.
REQ-026 SHALL drive out_ctrl = 0 whenever out_valid = 0; out_data is don't-care.
REQ-027 SHALL, on flush, go EMPTY at the next edge and zero both ctrl fields, discarding any same-cycle push or pop.
REQ-028 SHALL give flush priority over freeze.
REQ-029 SHALL, while freeze=1 and flush=0, hold all state, counter and data.
REQ-030 SHALL never reorder or duplicate entries; skid data leaves only via main.
REQ-031 SHALL increment bubble_cnt on each edge where freeze=0, flush=0, out_ready=1 and state=EMPTY, saturating at all-ones.
REQ-032 SHALL leave bubble_cnt unchanged on flush.
REQ-033 SHALL drive occupancy = 0/1/2 for EMPTY/ONE/TWO.

Reset
REQ-034 SHALL, on rst asserted, asynchronously force state EMPTY, all ctrl and data fields to 0, bubble_cnt to 0, in_ready 0, out_valid 0 and occupancy 0.
REQ-035 SHALL, after rst deasserts, assert in_ready at the first edge where freeze=0.
REQ-036 SHALL treat rst mid-transfer as a full drop of held entries; nothing is replayed.

Structure
REQ-037 SHALL place the state enumeration (EMPTY/ONE/TWO) and occupancy constants in the shared pipeline package.
REQ-038 SHALL instantiate one sub-module, sat_counter (parameter CNTW), for bubble_cnt; all else is flat.
REQ-039 SHALL be instantiable as any ID/EXE/MEM stage register by CW/DW choice alone.

Verification
REQ-040 SHALL cover streaming: out_ready=1, push data 1..8 back-to-back -> out_data 1..8 on consecutive cycles one cycle later, occupancy stays 1.
REQ-041 SHALL cover backpressure: push A,B,C with out_ready=0 -> occupancy 2, in_ready=0, C held upstream; raise out_ready -> A,B,C in order.
REQ-042 SHALL cover flush in TWO with push and pop active -> next cycle occupancy 0, out_valid 0, out_ctrl 0, nothing delivered.
REQ-043 SHALL cover freeze 5 cycles in ONE with in_valid=out_ready=1 -> no transfer, state, data and bubble_cnt unchanged; resumes after.
REQ-044 SHALL cover bubble counting: CNTW=4, EMPTY, out_ready=1 for 20 cycles -> bubble_cnt saturates at 15; flush keeps it at 15; rst clears it to 0.
REQ-045 SHALL cover async reset asserted between edges while in TWO -> outputs zero immediately, without waiting for a clock edge.
